lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator that drives the data-memory request/response interface from the core's execute stage. It accepts one load or store per transaction and checks alignment. It generates word-aligned addresses, byte enables and lane-replicated write data, waits for the memory's grant and response, and returns sign- or zero-extended load data. The core stalls on busy while a transaction is outstanding.

Parameters:
s, 32, address/data width; only 32 is legal (byte-lane logic fixed at 4 lanes)
TIMEOUT, 16, max cycles in WAIT before error response; legal range 1..255

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core request present
req_ready  out  1  block can accept request (IDLE only)
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
req_addr  in  s  byte address
req_wdata  in  s  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  s  extended load data (0 for stores/errors)
resp_err  out  1  misaligned/illegal/timeout, valid with resp_valid
busy  out  1  state != IDLE; core stall
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  s  {req_addr[s-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  s  lane-replicated store data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response (load data or store ack)
mem_rdata  in  s  memory read word

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; busy=0; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid=1 in IDLE, and req_we/size/unsigned/addr/wdata are latched.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=3 -> RESP with err=1. No memory access is made.
  - Otherwise -> REQ.
- REQ: mem_req=1. mem_we/addr/be/wdata come from registers and stay stable until grant. mem_gnt=1 -> WAIT, counter cleared. mem_rvalid is ignored in REQ.
- Byte enables/data:
  - byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - word: be=4'b1111, wdata unchanged.
  - Loads drive the same be; mem_wdata is don't-care but held at the registered value.
- WAIT: mem_req=0; the counter increments each cycle.
  - mem_rvalid=1 -> RESP with err=0. For loads, resp_rdata = mem_rdata>>(8*addr[1:0]), truncated to size, then extended per req_unsigned. For stores, resp_rdata=0.
  - Counter reaches TIMEOUT without rvalid -> RESP with err=1, rdata=0.
  - rvalid and the timeout in the same cycle: rvalid wins.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err registered; next state IDLE. Outside RESP, resp_valid=0 and resp_rdata/resp_err hold their last values.
- Latency: minimum 4 cycles from acceptance to resp_valid (accept, REQ with gnt, WAIT with rvalid, RESP). Error path is 2 cycles (accept, RESP). Back-to-back throughput is one request per ≥2 cycles.
- req_ready=0 and busy=1 in REQ/WAIT/RESP. req_valid is ignored there; the core must hold the request until a cycle where req_ready=1.
- Reset mid-transaction: IDLE on the next edge, mem_req=0. A late mem_rvalid arriving in IDLE is ignored and produces no response.
- A spurious mem_rvalid or mem_gnt in IDLE/RESP is ignored.

Test Plan:
- Aligned word store: addr=0x104, wdata=0xDEADBEEF, gnt in REQ, rvalid 2 cycles later -> mem_addr=0x104, be=1111, mem_wdata=0xDEADBEEF, mem_we=1, resp_valid pulse with err=0, rdata=0.
- Byte loads: addr=0x203, mem_rdata=0x80112233. Signed -> rdata=0xFFFFFF80; unsigned -> 0x00000080; be=1000 in both.
- Half store: addr=0x12, wdata=0x0000A5C3 -> mem_addr=0x10, be=1100, mem_wdata=0xA5C3A5C3. Half load from 0x12 with mem_rdata=0x7FFE0000, signed -> 0x00007FFE.
- Misaligned/illegal: word load addr=0x102; half addr=0x1; size=3 -> each gives mem_req never asserted, resp_valid 1 cycle after acceptance with err=1.
- Grant stall and timeout: gnt withheld 5 cycles -> mem_req and mem_addr/be stable throughout. Then no rvalid for TIMEOUT=16 cycles -> resp_err=1, rdata=0. Repeat with rvalid on the 16th cycle -> err=0.
- Reset mid-WAIT: assert rst for 1 cycle, then drive mem_rvalid -> no resp_valid, busy=0, req_ready=1. A new word load then completes normally.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//    Load/store initiator between the core execute stage and the data memory.
//    It takes one load or store at a time and rejects misaligned or illegal
//    sizes without touching memory. It issues a word-aligned request with byte
//    enables and lane-replicated store data, then waits for grant and response
//    and returns sign- or zero-extended load data.
//
// Ports
//    clk, rst         rising-edge clock, synchronous active-high reset
//    req_*            core request (valid/ready handshake, accepted in IDLE only)
//    resp_*           one-cycle completion pulse with load data and error flag
//    busy             transaction outstanding, core must stall
//    mem_req/we/...   memory request channel, held stable until mem_gnt
//    mem_rvalid/rdata memory response (load data or store acknowledge)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a new request
// REQ     | mem_req asserted, waiting for mem_gnt
// WAIT    | granted, waiting for mem_rvalid or TIMEOUT
// RESP    | resp_valid pulse, result registered
module lsu_mem_master #(
   parameter int s       = 32,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   input  logic [s-1:0] req_addr,
   input  logic [s-1:0] req_wdata,
   output logic         resp_valid,
   output logic [s-1:0] resp_rdata,
   output logic         resp_err,
   output logic         busy,
   output logic         mem_req,
   output logic         mem_we,
   output logic [s-1:0] mem_addr,
   output logic [3:0]   mem_be,
   output logic [s-1:0] mem_wdata,
   input  logic         mem_gnt,
   input  logic         mem_rvalid,
   input  logic [s-1:0] mem_rdata
);

   if (s != 32) begin : g_bad_width
      $error("lsu_mem_master: only s=32 is supported");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("lsu_mem_master: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e       state_q,      state_d;
   logic [1:0]   size_q,       size_d;
   logic         uns_q,        uns_d;
   logic [1:0]   off_q,        off_d;
   logic         mem_we_q,     mem_we_d;
   logic [s-1:0] mem_addr_q,   mem_addr_d;
   logic [3:0]   mem_be_q,     mem_be_d;
   logic [s-1:0] mem_wdata_q,  mem_wdata_d;
   logic [7:0]   cnt_q,        cnt_d;
   logic [s-1:0] resp_rdata_q, resp_rdata_d;
   logic         resp_err_q,   resp_err_d;

   logic         misaligned;
   logic [3:0]   be_base;
   logic [s-1:0] wdata_rep;
   logic [s-1:0] rd_shift;
   logic [s-1:0] rd_ext;

   // Request decode: alignment check, lane-0 byte enable pattern, replication.
   always_comb begin
      misaligned = 1'b0;
      be_base    = 4'b0000;
      wdata_rep  = req_wdata;
      case (req_size)
         2'd0: begin
            be_base   = 4'b0001;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            be_base    = 4'b0011;
            wdata_rep  = {2{req_wdata[15:0]}};
            misaligned = req_addr[0];
         end
         2'd2: begin
            be_base    = 4'b1111;
            misaligned = |req_addr[1:0];
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Load return path: move the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    rd_ext = {{(s-8){~uns_q & rd_shift[7]}}, rd_shift[7:0]};
         2'd1:    rd_ext = {{(s-16){~uns_q & rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      cnt_d        = cnt_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               size_d      = req_size;
               uns_d       = req_unsigned;
               off_d       = req_addr[1:0];
               mem_we_d    = req_we;
               mem_addr_d  = {req_addr[s-1:2], 2'b00};
               mem_be_d    = be_base << req_addr[1:0];
               mem_wdata_d = wdata_rep;
               if (misaligned) begin
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = ST_RESP;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = 8'(cnt_q + 8'd1);
            // rvalid takes priority over a timeout landing in the same cycle
            if (mem_rvalid) begin
               resp_err_d   = 1'b0;
               resp_rdata_d = mem_we_q ? '0 : rd_ext;
               state_d      = ST_RESP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
               state_d      = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         cnt_q        <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         cnt_q        <= cnt_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign mem_req    = (state_q == ST_REQ);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_mem_master #(.s(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          gnt_dly;  // REQ cycles before the one carrying mem_gnt
      int          rv_dly;   // WAIT cycle (1-based) carrying mem_rvalid, 0 = never
   } stim_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic        mwe;
      logic        mem;
      int          lat;      // cycles after acceptance until resp_valid is seen
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: derived from lane arithmetic, not from the RTL structure.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      int          nb, off;
      logic [31:0] mask, sh;
      e     = '{default: 0};
      off   = int'(s.addr[1:0]);
      nb    = (s.size == 2'd0) ? 1 : (s.size == 2'd1) ? 2 : 4;
      e.mwe = s.we;
      if (s.size == 2'd3 || (off % nb) != 0) begin
         e.err = 1'b1;
         e.lat = 1;
         return e;
      end
      e.mem   = 1'b1;
      e.maddr = s.addr & ~32'h3;
      e.be    = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = s.wdata[8*(i % nb) +: 8];
      if (s.rv_dly >= 1 && s.rv_dly <= TMO) begin
         e.lat = 2 + s.gnt_dly + s.rv_dly;
         if (!s.we) begin
            sh      = s.mrdata >> (8 * off);
            mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            e.rdata = sh & mask;
            if (!s.uns && nb < 4 && e.rdata[8*nb-1]) e.rdata = e.rdata | ~mask;
         end
      end else begin
         e.err = 1'b1;
         e.lat = 2 + s.gnt_dly + TMO;
      end
      return e;
   endfunction

   // Drives one transaction starting at a negedge in IDLE; returns observations.
   task automatic run_txn(input stim_t s, output exp_t o, output bit stable,
                          output bit pulse_ok, output bit tmo);
      int n, r, w;
      o = '{default: 0};
      stable = 1'b1; pulse_ok = 1'b1; tmo = 1'b0;
      n = 0; r = 0; w = 0;
      req_valid = 1'b1; req_we = s.we; req_size = s.size; req_unsigned = s.uns;
      req_addr = s.addr; req_wdata = s.wdata;
      @(posedge clk);
      @(negedge clk);
      // scramble request fields: the DUT must work from what it latched
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      forever begin
         n++;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (resp_valid) begin
            o.err = resp_err; o.rdata = resp_rdata; o.lat = n;
            req_valid = 1'b0;
            mem_rvalid = 1'($urandom);
            break;
         end
         req_valid = 1'($urandom);
         if (n > 600) begin
            tmo = 1'b1;
            break;
         end
         if (mem_req) begin
            if (!o.mem) begin
               o.mem = 1'b1; o.maddr = mem_addr; o.be = mem_be;
               o.mwdata = mem_wdata; o.mwe = mem_we;
            end else if (mem_addr !== o.maddr || mem_be !== o.be ||
                         mem_wdata !== o.mwdata || mem_we !== o.mwe) begin
               stable = 1'b0;
            end
            if (r == s.gnt_dly) mem_gnt = 1'b1;
            else mem_rvalid = 1'($urandom);
            r++;
         end else if (busy) begin
            w++;
            mem_gnt = 1'($urandom);
            if (w == s.rv_dly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = s.mrdata;
            end
         end else begin
            tmo = 1'b1;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      if (!tmo) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 ||
             resp_rdata !== o.rdata || resp_err !== o.err) pulse_ok = 1'b0;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic apply_and_check(input string tag, input stim_t s, input exp_t e);
      exp_t o;
      bit   stable, pulse_ok, tmo;
      run_txn(s, o, stable, pulse_ok, tmo);
      if (tmo) begin
         chk({tag, " no_resp"}, 32'd1, 32'd0);
         rst = 1'b1;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         return;
      end
      chk({tag, " err"},   32'(o.err), 32'(e.err));
      chk({tag, " rdata"}, o.rdata, e.rdata);
      chk({tag, " mem_access"}, 32'(o.mem), 32'(e.mem));
      chk({tag, " latency"}, 32'(o.lat), 32'(e.lat));
      chk({tag, " pulse_hold"}, 32'(pulse_ok), 32'd1);
      if (e.mem) begin
         chk({tag, " mem_addr"},  o.maddr, e.maddr);
         chk({tag, " mem_be"},    32'(o.be), 32'(e.be));
         chk({tag, " mem_wdata"}, o.mwdata, e.mwdata);
         chk({tag, " mem_we"},    32'(o.mwe), 32'(e.mwe));
         chk({tag, " req_stable"}, 32'(stable), 32'd1);
      end
   endtask

   vec_t  vt[12];
   stim_t rs;

   initial begin
      vt[0]  = '{'{1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 32'hCAFEF00D, 0, 2},
                 '{1'b0, 32'h0, 32'h104, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 4}};
      vt[1]  = '{'{1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80112233, 0, 1},
                 '{1'b0, 32'hFFFFFF80, 32'h200, 4'h8, 32'h0, 1'b0, 1'b1, 3}};
      vt[2]  = '{'{1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80112233, 0, 1},
                 '{1'b0, 32'h00000080, 32'h200, 4'h8, 32'h0, 1'b0, 1'b1, 3}};
      vt[3]  = '{'{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000A5C3, 32'hCAFEF00D, 1, 1},
                 '{1'b0, 32'h0, 32'h10, 4'hC, 32'hA5C3A5C3, 1'b1, 1'b1, 4}};
      vt[4]  = '{'{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h7FFE0000, 0, 1},
                 '{1'b0, 32'h00007FFE, 32'h10, 4'hC, 32'h0, 1'b0, 1'b1, 3}};
      vt[5]  = '{'{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1},
                 '{1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1}};
      vt[6]  = '{'{1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 32'h0, 0, 1},
                 '{1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1}};
      vt[7]  = '{'{1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 0, 1},
                 '{1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1}};
      vt[8]  = '{'{1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h12345678, 5, 0},
                 '{1'b1, 32'h0, 32'h300, 4'hF, 32'h0, 1'b0, 1'b1, 23}};
      vt[9]  = '{'{1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h12345678, 5, 16},
                 '{1'b0, 32'h12345678, 32'h300, 4'hF, 32'h0, 1'b0, 1'b1, 23}};
      vt[10] = '{'{1'b0, 2'd2, 1'b1, 32'h300, 32'h0, 32'h12345678, 0, 17},
                 '{1'b1, 32'h0, 32'h300, 4'hF, 32'h0, 1'b0, 1'b1, 18}};
      vt[11] = '{'{1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h80011234, 2, 3},
                 '{1'b0, 32'hFFFF8001, 32'h20, 4'hC, 32'h0, 1'b0, 1'b1, 7}};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);

      chk("reset req_ready",  32'(req_ready), 32'd1);
      chk("reset busy",       32'(busy), 32'd0);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_err",   32'(resp_err), 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset mem_req",    32'(mem_req), 32'd0);
      chk("reset mem_we",     32'(mem_we), 32'd0);
      chk("reset mem_addr",   mem_addr, 32'd0);
      chk("reset mem_be",     32'(mem_be), 32'd0);
      chk("reset mem_wdata",  mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         apply_and_check($sformatf("vec%0d", i), vt[i].s, vt[i].e);

      // reset while in WAIT, followed by a late rvalid that must be ignored
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h400; req_wdata = '0;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_gnt = 1'b0;
      chk("midwait busy", 32'(busy), 32'd1);
      chk("midwait mem_req", 32'(mem_req), 32'd0);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         mem_rvalid = 1'b0;
         chk($sformatf("late rvalid resp_valid %0d", k), 32'(resp_valid), 32'd0);
         chk($sformatf("late rvalid busy %0d", k), 32'(busy), 32'd0);
      end
      rs = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0BADF00D, 0, 1};
      apply_and_check("post_reset load", rs, model(rs));

      for (int i = 0; i < 150; i++) begin
         int k;
         rs.we     = 1'($urandom);
         rs.size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rs.uns    = 1'($urandom);
         rs.addr   = $urandom;
         rs.wdata  = $urandom;
         rs.mrdata = $urandom;
         rs.gnt_dly = int'($urandom_range(0, 3));
         k = int'($urandom_range(0, 9));
         rs.rv_dly = (k == 0) ? 0 : (k == 1) ? TMO : (k == 2) ? TMO + 1
                   : int'($urandom_range(1, 4));
         apply_and_check($sformatf("rand%0d", i), rs, model(rs));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
